// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers; MADD/MADDU enabled by `define MULDIV_MADD_EN.
// Latency: MUL_LATENCY cycles for multiplies, WIDTH+1 cycles for divides, MTHI/MTLO at the accepting edge.
// Backpressure: busy holds off new starts (ignored while busy); cancel aborts and leaves HI/LO untouched.
module muldiv_unit #(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] t,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;
   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mul_a, mul_b, quo, rem, dvsr, s_orig;
   logic             mul_sgn, mul_acc, neg_q, neg_r, dz;

   logic             div_sgn;
   logic [WIDTH-1:0] s_abs, t_abs;
   logic [2*WIDTH-1:0] a_x, b_x, prod, acc;
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] q_fix, r_fix;

   assign div_sgn = (op == 3'b010);
   assign s_abs   = (div_sgn && s[WIDTH-1]) ? -s : s;
   assign t_abs   = (div_sgn && t[WIDTH-1]) ? -t : t;

   // Sign-extend to 2*WIDTH so the truncated product is correct for both signed and unsigned forms
   assign a_x  = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a};
   assign b_x  = {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};
   assign prod = a_x * b_x;
   assign acc  = mul_acc ? ({hi, lo} + prod) : prod;

   assign shifted = {rem, quo[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvsr};
   assign q_fix   = neg_q ? -quo : quo;
   assign r_fix   = neg_r ? -rem : rem;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         mul_sgn  <= 1'b0;
         mul_acc  <= 1'b0;
         quo      <= '0;
         rem      <= '0;
         dvsr     <= '0;
         s_orig   <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz       <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         if (cancel && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !cancel) begin
                     case (op)
                        3'b000, 3'b001: begin
                           mul_a   <= s;
                           mul_b   <= t;
                           mul_sgn <= ~op[0];
                           mul_acc <= 1'b0;
                           cnt     <= CW'(MUL_LATENCY - 1);
                           busy    <= 1'b1;
                           state   <= MUL;
                        end
                        3'b010, 3'b011: begin
                           quo    <= s_abs;
                           dvsr   <= t_abs;
                           rem    <= '0;
                           s_orig <= s;
                           neg_q  <= div_sgn & (s[WIDTH-1] ^ t[WIDTH-1]);
                           neg_r  <= div_sgn & s[WIDTH-1];
                           dz     <= (t == '0);
                           cnt    <= CW'(WIDTH - 1);
                           busy   <= 1'b1;
                           state  <= DIV_ITER;
                        end
                        3'b100: hi <= s;
                        3'b101: lo <= s;
`ifdef MULDIV_MADD_EN
                        3'b110, 3'b111: begin
                           mul_a   <= s;
                           mul_b   <= t;
                           mul_sgn <= ~op[0];
                           mul_acc <= 1'b1;
                           cnt     <= CW'(MUL_LATENCY - 1);
                           busy    <= 1'b1;
                           state   <= MUL;
                        end
`endif
                        default: ;
                     endcase
                  end
               end
               MUL: begin
                  if (cnt == '0) begin
                     {hi, lo} <= acc;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               DIV_ITER: begin
                  // Restoring step: a clear borrow bit means the trial subtraction fits
                  if (!trial[WIDTH]) begin
                     rem <= trial[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= shifted[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
                  if (cnt == '0) state <= DIV_FIX;
                  else           cnt   <= cnt - 1'b1;
               end
               DIV_FIX: begin
                  if (dz) begin
                     lo       <= '1;
                     hi       <= s_orig;
                     div_zero <= 1'b1;
                  end else begin
                     lo <= q_fix;
                     hi <= r_fix;
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

   localparam int W  = 32;
   localparam int ML = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          cancel = 1'b0;
   logic [2:0]    op = 3'b000;
   logic [W-1:0]  s = '0;
   logic [W-1:0]  t = '0;
   logic          busy, done, div_zero;
   logic [W-1:0]  hi, lo;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   muldiv_unit #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .s(s), .t(t),
      .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic on the architectural HI/LO pair
   task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic dz);
      longint ss, tt, q, r;
      logic [63:0] up;
      dz  = 1'b0;
      lat = 0;
      ss  = longint'($signed(a));
      tt  = longint'($signed(b));
      up  = {32'b0, a} * {32'b0, b};
      case (o)
         3'd0: begin {exp_hi, exp_lo} = ss * tt; lat = ML; end
         3'd1: begin {exp_hi, exp_lo} = up;      lat = ML; end
         3'd2, 3'd3: begin
            lat = W + 1;
            if (b == 0) begin
               exp_hi = a; exp_lo = '1; dz = 1'b1;
            end else if (o == 3'd2) begin
               q = ss / tt; r = ss % tt;
               exp_lo = q[31:0]; exp_hi = r[31:0];
            end else begin
               exp_lo = a / b; exp_hi = a % b;
            end
         end
         3'd4: exp_hi = a;
         3'd5: exp_lo = a;
`ifdef MULDIV_MADD_EN
         3'd6: begin {exp_hi, exp_lo} = {exp_hi, exp_lo} + 64'(ss * tt); lat = ML; end
         3'd7: begin {exp_hi, exp_lo} = {exp_hi, exp_lo} + up;           lat = ML; end
`endif
         default: ;
      endcase
   endtask

   task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      logic dz;
      logic [W-1:0] ph, pl;
      ph = exp_hi; pl = exp_lo;
      model(o, a, b, lat, dz);
      @(negedge clk); start = 1'b1; op = o; s = a; t = b;
      @(posedge clk); #1; start = 1'b0;
      if (lat == 0) begin
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL immediate op=%0d: busy=%b done=%b hi=%h lo=%h, required busy=0 done=0 hi=%h lo=%h",
                     o, busy, done, hi, lo, exp_hi, exp_lo);
         end
      end else begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0 || hi !== ph || lo !== pl) begin
            errors++;
            $display("FAIL accept op=%0d: busy=%b done=%b hi=%h lo=%h, required busy=1 done=0 hi=%h lo=%h",
                     o, busy, done, hi, lo, ph, pl);
         end
         for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k < lat) begin
               if (busy !== 1'b1 || done !== 1'b0) begin
                  errors++;
                  $display("FAIL inflight op=%0d cycle=%0d: busy=%b done=%b, required busy=1 done=0",
                           o, k, busy, done);
               end
            end else if (busy !== 1'b0 || done !== 1'b1 || div_zero !== dz ||
                         hi !== exp_hi || lo !== exp_lo) begin
               errors++;
               $display("FAIL result op=%0d s=%h t=%h: busy=%b done=%b dz=%b hi=%h lo=%h, required busy=0 done=1 dz=%b hi=%h lo=%h",
                        o, a, b, busy, done, div_zero, hi, lo, dz, exp_hi, exp_lo);
            end
         end
      end
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen || hi !== exp_hi || lo !== exp_lo) begin
         errors++;
         $display("FAIL %s: activity=%b hi=%h lo=%h, required activity=0 hi=%h lo=%h",
                  name, seen, hi, lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0 || div_zero !== 0) begin
         errors++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b, required all zero",
                  hi, lo, busy, done, div_zero);
      end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_mult;
      do_op(3'd0, 32'hFFFFFFFE, 32'd3);
      checks++;
      if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin
         errors++;
         $display("FAIL mult_plan: got %h, required FFFFFFFFFFFFFFFA", {hi, lo});
      end
      do_op(3'd0, 32'h80000000, 32'h80000000);
      do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
   endtask

   task automatic test_back_to_back;
      do_op(3'd1, 32'hFFFFFFFE, 32'd3);
      checks++;
      if ({hi, lo} !== 64'h00000002_FFFFFFFA) begin
         errors++;
         $display("FAIL multu_plan: got %h, required 00000002FFFFFFFA", {hi, lo});
      end
      do_op(3'd5, 32'h55, 32'd0);
      do_op(3'd2, 32'd100, 32'd7);
      do_op(3'd0, 32'd12345, 32'hFFFFFF00);
   endtask

   task automatic test_div;
      do_op(3'd2, 32'hFFFFFFF9, 32'd2);
      checks++;
      if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL div_plan: hi=%h lo=%h, required hi=FFFFFFFF lo=FFFFFFFD", hi, lo);
      end
      do_op(3'd3, 32'h00001234, 32'd0);
      do_op(3'd2, 32'hFFFFFFFB, 32'd0);
      do_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
      do_op(3'd2, 32'd7, 32'hFFFFFFFE);
      do_op(3'd3, 32'hFFFFFFFF, 32'd1);
   endtask

   task automatic test_madd;
      do_op(3'd4, 32'h00000001, 32'd0);
      do_op(3'd5, 32'hFFFFFFF0, 32'd0);
      do_op(3'd6, 32'hFFFFFFFF, 32'd5);
      do_op(3'd7, 32'hFFFFFFFF, 32'd5);
   endtask

   task automatic test_cancel;
      do_op(3'd4, 32'h1111, 32'd0);
      do_op(3'd5, 32'h2222, 32'd0);
      @(negedge clk); start = 1'b1; op = 3'd2; s = 32'd100; t = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); cancel = 1'b1;
      @(posedge clk); #1; cancel = 1'b0;
      expect_quiet("cancel_div", 40);
      do_op(3'd0, 32'd6, 32'hFFFFFFF9);
      @(negedge clk); start = 1'b1; op = 3'd1; s = 32'd9; t = 32'd9;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); cancel = 1'b1;
      @(posedge clk); #1; cancel = 1'b0;
      expect_quiet("cancel_mul", 6);
      @(negedge clk); start = 1'b1; cancel = 1'b1; op = 3'd4; s = 32'hFFFF;
      @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
      expect_quiet("cancel_mthi", 1);
      @(negedge clk); start = 1'b1; cancel = 1'b1; op = 3'd2; s = 32'd50; t = 32'd3;
      @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
      expect_quiet("cancel_start_div", 40);
   endtask

   task automatic test_ignore;
      int lat;
      logic dz, got;
      logic [W-1:0] ph;
      ph = exp_hi;
      model(3'd3, 32'd1000, 32'd3, lat, dz);
      @(negedge clk); start = 1'b1; op = 3'd3; s = 32'd1000; t = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); start = 1'b1; op = 3'd4; s = 32'hDEAD;
      @(posedge clk); #1; start = 1'b0;
      checks++;
      if (hi !== ph || busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_ignore: hi=%h busy=%b, required hi=%h busy=1", hi, busy, ph);
      end
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got || hi !== exp_hi || lo !== exp_lo) begin
         errors++;
         $display("FAIL busy_ignore_result: done_seen=%b hi=%h lo=%h, required done_seen=1 hi=%h lo=%h",
                  got, hi, lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset_mid;
      do_op(3'd4, 32'hAAAA, 32'd0);
      do_op(3'd5, 32'hBBBB, 32'd0);
      @(negedge clk); start = 1'b1; op = 3'd3; s = 32'd77; t = 32'd5;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
         errors++;
         $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, required all zero", hi, lo, busy, done);
      end
      @(negedge clk); reset = 1'b1;
      exp_hi = '0; exp_lo = '0;
      expect_quiet("reset_mid_quiet", 40);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h80000000;
         1: return 32'hFFFFFFFF;
         2: return 32'd0;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         do_op(3'($urandom_range(0, 7)), pick(), pick());
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_back_to_back;
      test_div;
      test_madd;
      test_cancel;
      test_ignore;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers, fed from the EX stage of the pipelined CPU.
- Multiplies run in a fixed-latency pipeline of MUL_LATENCY cycles; divides use an iterative radix-2 restoring algorithm.
- `busy` drives the hazard unit's stall. `cancel` aborts an in-flight operation when the pipeline flushes on a branch, jump or exception.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LATENCY, 2, cycles from start acceptance to result for MULT/MULTU (legal range 1..4).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request a new operation; sampled when busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
- s  in  WIDTH  operand rs (dividend / multiplicand / MTHI/MTLO data).
- t  in  WIDTH  operand rt (divisor / multiplier).
- cancel  in  1  abort the in-flight operation; HI/LO are left untouched.
- busy  out  1  operation in progress; pipeline must stall MFHI/MFLO and new starts.
- done  out  1  one-cycle pulse in the cycle HI/LO take a new result.
- div_zero  out  1  pulses with done when a divide had t=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset:
  - reset=0 at a clock edge sets hi=0, lo=0, busy=0, done=0, div_zero=0 and state=IDLE.
  - Reset mid-operation discards it with no done pulse.
- States: IDLE, MUL, DIV_ITER, DIV_FIX.
- IDLE, start=1, cancel=0:
  - MULT/MULTU: latch operands, busy=1 next cycle, enter MUL with counter=MUL_LATENCY-1.
  - DIV/DIVU: latch absolute values (signed op) and sign flags, enter DIV_ITER with counter=WIDTH-1.
  - MTHI/MTLO: write hi (resp. lo)=s at that edge. busy stays 0 and done is not pulsed.
- MUL:
  - Counter decrements each cycle.
  - When it reaches 0, {hi,lo} gets the 2*WIDTH product; signed for MULT, unsigned for MULTU.
  - done=1 for one cycle, busy=0 and return to IDLE.
  - Result is visible exactly MUL_LATENCY cycles after the accepting edge.
- DIV_ITER:
  - One quotient bit per cycle for WIDTH cycles, then DIV_FIX.
- DIV_FIX:
  - Apply signs: quotient truncates toward zero; remainder takes the dividend's sign.
  - Write lo=quotient, hi=remainder, pulse done and return to IDLE.
  - Total divide latency is WIDTH+1 cycles after the accepting edge.
- Divide by zero:
  - Takes the full latency.
  - lo=all ones, hi=original s (unsigned magnitude path, sign fixup skipped), div_zero=1 with done.
- Signed overflow: MIN/-1 gives lo=MIN, hi=0, with no flag.
- start while busy=1 is ignored; the hazard unit is responsible for holding it.
- cancel=1 in any non-IDLE state:
  - Next state is IDLE and busy=0 next cycle.
  - hi/lo are unchanged and there is no done pulse.
- cancel and start in the same cycle: cancel wins and start is dropped, including when IDLE.
- Completion cycle: done and busy fall together. A start in the following cycle is accepted normally, giving back-to-back operations with no bubble beyond that cycle.
- MTHI/MTLO while busy are ignored.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: op 110/111 (MADD/MADDU) compute {hi,lo} + s*t, signed/unsigned, wrapping modulo 2^(2*WIDTH).
  - Accumulation happens at MUL completion, so the latency is the same as MULT.
  - {hi,lo} sampled at completion is the accumulator source.
- Not defined: op 110/111 are no-ops; busy, done, hi and lo are unaffected.

Test Plan (WIDTH=32, MUL_LATENCY=2):
- MULT s=0xFFFFFFFE t=3, start at edge 0 -> busy=1 edge 1, done=1 edge 2, hi=0xFFFFFFFF lo=0xFFFFFFFA.
- MULTU s=0xFFFFFFFE t=3 -> hi=0x00000002 lo=0xFFFFFFFA after 2 cycles; a back-to-back MTLO s=0x55 next cycle -> lo=0x00000055.
- DIV s=0xFFFFFFF9 (-7) t=2 -> done at edge 33, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
- DIVU s=0x00001234 t=0 -> done at edge 33, lo=0xFFFFFFFF, hi=0x00001234, div_zero=1.
- DIV started then cancel=1 at edge 10 -> busy=0 edge 11, no done, hi/lo unchanged; a new MULT at edge 12 is accepted and completes at edge 14.
- Reset (reset=0) at edge 5 of DIVU with hi/lo previously 0xAAAA/0xBBBB -> hi=0, lo=0, busy=0, no done pulse afterwards.
